// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and flag bit positions for the ALU datapath.
package alu_pkg;

  localparam logic [5:0] OP_MOV_I = 6'b000000;
  localparam logic [5:0] OP_MOV_R = 6'b000001;
  localparam logic [5:0] OP_ADD   = 6'b000100;
  localparam logic [5:0] OP_SUB   = 6'b000101;
  localparam logic [5:0] OP_NEG   = 6'b000110;
  localparam logic [5:0] OP_MUL   = 6'b000111;
  localparam logic [5:0] OP_DIV   = 6'b001000;
  localparam logic [5:0] OP_OR    = 6'b001001;
  localparam logic [5:0] OP_XOR   = 6'b001010;
  localparam logic [5:0] OP_NAND  = 6'b001011;
  localparam logic [5:0] OP_NOR   = 6'b001100;
  localparam logic [5:0] OP_XNOR  = 6'b001101;
  localparam logic [5:0] OP_NOT   = 6'b001110;
  localparam logic [5:0] OP_LLSH  = 6'b001111;
  localparam logic [5:0] OP_LRSH  = 6'b010000;

  typedef enum logic [1:0] {IDLE, EXEC_MUL, EXEC_DIV, DONE} alu_state_e;

  localparam int FLG_ZERO    = 0;
  localparam int FLG_CARRY   = 1;
  localparam int FLG_OVF     = 2;
  localparam int FLG_DIV0    = 3;
  localparam int FLG_ILLEGAL = 4;
  localparam int FLG_W       = 5;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring divider, one quotient bit per step; the caller owns the step counter
// and flags the final step with i_last. Only instantiated when ALU_DIV_EN is defined.
module alu_div_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_last,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  // o_quot/o_rem are the values after the current step, so the caller can
  // capture the final answer on the same edge as the last step.
  assign w_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_div};
  assign o_rem   = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_quot  = {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
  assign o_done  = i_step && i_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_div  <= '0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_div  <= i_divisor;
    end else if (i_step) begin
      r_rem  <= o_rem;
      r_quot <= o_quot;
    end
  end

endmodule

// File: rtl/alu_core.sv
// Handshaked ALU: single-cycle logic/add/shift, iterative MUL, optional restoring
// DIV (built only when ALU_DIV_EN is defined; otherwise DIV decodes as illegal).
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPW-1:0]     opcode,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [FLG_W-1:0]   flags,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  alu_state_e         r_state, w_state_nxt, w_dispatch;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_result, r_mul_a, w_mul_acc;
  logic [WIDTH-1:0]   r_mul_b, w_sc_lo, w_sc_hi;
  logic [FLG_W-1:0]   r_flags, w_sc_flags;
  logic [WIDTH:0]     w_sum, w_diff;
  logic               w_accept, w_cnt_last, w_is_mul, w_is_div_long;

  assign in_ready   = (r_state == IDLE) || (r_state == DONE && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = (r_state == DONE);
  assign busy       = (r_state == EXEC_MUL) || (r_state == EXEC_DIV);
  assign result     = r_result;
  assign flags      = r_flags;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_is_mul   = (opcode == OPW'(OP_MUL));
  assign w_sum      = {1'b0, src_a} + {1'b0, src_b};
  assign w_diff     = {1'b0, src_a} - {1'b0, src_b};
  assign w_mul_acc  = r_result + (r_mul_b[0] ? r_mul_a : '0);

`ifdef ALU_DIV_EN
  logic             w_div_done;
  logic [WIDTH-1:0] w_div_quot, w_div_rem;

  // Divide-by-zero is resolved in the single-cycle path and never starts the divider.
  assign w_is_div_long = (opcode == OPW'(OP_DIV)) && (src_b != '0);

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_accept && w_is_div_long),
    .i_step     (r_state == EXEC_DIV),
    .i_last     (w_cnt_last),
    .i_dividend (src_a),
    .i_divisor  (src_b),
    .o_done     (w_div_done),
    .o_quot     (w_div_quot),
    .o_rem      (w_div_rem)
  );
`else
  assign w_is_div_long = 1'b0;
`endif

  always_comb begin
    w_sc_lo    = '0;
    w_sc_hi    = '0;
    w_sc_flags = '0;
    case (opcode)
      OPW'(OP_MOV_I), OPW'(OP_MOV_R): w_sc_lo = src_a;
      OPW'(OP_ADD): begin
        w_sc_lo               = w_sum[WIDTH-1:0];
        w_sc_flags[FLG_CARRY] = w_sum[WIDTH];
        w_sc_flags[FLG_OVF]   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      OPW'(OP_SUB): begin
        w_sc_lo               = w_diff[WIDTH-1:0];
        w_sc_flags[FLG_CARRY] = ~w_diff[WIDTH];
        w_sc_flags[FLG_OVF]   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      OPW'(OP_NEG): begin
        w_sc_lo             = -src_a;
        w_sc_flags[FLG_OVF] = (src_a == {1'b1, {(WIDTH-1){1'b0}}});
      end
`ifdef ALU_DIV_EN
      OPW'(OP_DIV): begin
        w_sc_lo              = '1;
        w_sc_hi              = src_a;
        w_sc_flags[FLG_DIV0] = 1'b1;
      end
`endif
      OPW'(OP_OR):   w_sc_lo = src_a | src_b;
      OPW'(OP_XOR):  w_sc_lo = src_a ^ src_b;
      OPW'(OP_NAND): w_sc_lo = ~(src_a & src_b);
      OPW'(OP_NOR):  w_sc_lo = ~(src_a | src_b);
      OPW'(OP_XNOR): w_sc_lo = ~(src_a ^ src_b);
      OPW'(OP_NOT):  w_sc_lo = ~src_a;
      OPW'(OP_LLSH): w_sc_lo = (src_b >= WIDTH'(WIDTH)) ? '0 : (src_a << src_b);
      OPW'(OP_LRSH): w_sc_lo = (src_b >= WIDTH'(WIDTH)) ? '0 : (src_a >> src_b);
      default:       w_sc_flags[FLG_ILLEGAL] = 1'b1;
    endcase
    w_sc_flags[FLG_ZERO] = ~w_sc_flags[FLG_ILLEGAL] && (w_sc_lo == '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dispatch  = w_is_mul ? EXEC_MUL : (w_is_div_long ? EXEC_DIV : DONE);
    case (r_state)
      IDLE:               if (w_accept) w_state_nxt = w_dispatch;
      EXEC_MUL, EXEC_DIV: if (w_cnt_last) w_state_nxt = DONE;
      DONE:               if (out_ready) w_state_nxt = w_accept ? w_dispatch : IDLE;
      default:            w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // During MUL, r_result doubles as the shift-add accumulator; out_valid is low then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_mul_a <= {{WIDTH{1'b0}}, src_a};
      r_mul_b <= src_b;
      if (w_is_mul || w_is_div_long) begin
        r_result <= '0;
        r_flags  <= '0;
      end else begin
        r_result <= {w_sc_hi, w_sc_lo};
        r_flags  <= w_sc_flags;
      end
    end else if (r_state == EXEC_MUL) begin
      r_cnt    <= r_cnt + CW'(1);
      r_mul_a  <= r_mul_a << 1;
      r_mul_b  <= r_mul_b >> 1;
      r_result <= w_mul_acc;
      if (w_cnt_last) begin
        r_flags[FLG_OVF]  <= |w_mul_acc[2*WIDTH-1:WIDTH];
        r_flags[FLG_ZERO] <= (w_mul_acc[WIDTH-1:0] == '0);
      end
    end
`ifdef ALU_DIV_EN
    else if (r_state == EXEC_DIV) begin
      r_cnt <= r_cnt + CW'(1);
      if (w_div_done) begin
        r_result          <= {w_div_rem, w_div_quot};
        r_flags[FLG_ZERO] <= (w_div_quot == '0);
      end
    end
`endif
  end

endmodule

// File: doc/alu_core.md
# alu_core

Parametrised, handshaked ALU for the Harvard datapath. It accepts one decoded operation at a time (6-bit opcode plus two register operands) and executes logic, add and shift ops in one cycle. MUL uses an iterative shift-add engine and DIV a restoring divider. Each result and its flags are held until the writeback stage takes them. It sits between operand fetch from the register/data memory and writeback.

## Interface
- WIDTH, 16: operand width, even, ≥4.
- OPW, 6: opcode width, i.e. bits [31:26] of the instruction word.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  ALU can accept this cycle.
- opcode  in  OPW  operation select.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- out_valid  out  1  result held.
- out_ready  in  1  writeback takes the result.
- result  out  2*WIDTH  low half is the primary result; high half is the MUL product high or the DIV remainder, zero otherwise.
- flags  out  5  {illegal, div0, ovf, carry, zero}; zero and ovf are computed on the low half.
- busy  out  1  MUL/DIV iteration in progress.

## Operation
- Opcodes and their results:
  - 000000/000001 MOV: result src_a.
  - 000100 ADD: a+b. carry is the carry-out; ovf is signed overflow.
  - 000101 SUB: a−b. carry=1 when there is no borrow; ovf is signed overflow.
  - 000110 NEG: −a. ovf when a is the signed minimum.
  - 000111 MUL: unsigned a×b, full 2*WIDTH product. ovf when the high half is nonzero.
  - 001000 DIV: unsigned a÷b. Low half is the quotient, high half the remainder.
  - 001001 OR, 001010 XOR, 001011 NAND, 001100 NOR, 001101 XNOR: bitwise a op b.
  - 001110 NOT: ~a.
  - 001111 LLSH / 010000 LRSH: logical shift of a by the full value of b. Any b ≥ WIDTH yields 0.
- Any other opcode: result 0 with illegal=1, completed as a single-cycle op.
- Flags that do not apply to an op are 0.
- DIV with b=0: completes in one cycle. Quotient is all-ones, remainder is a, div0=1.
- FSM states:
  - IDLE: accept operation → EXEC_MUL, EXEC_DIV, or DONE (single-cycle ops).
  - EXEC_MUL / EXEC_DIV: counter runs 0..WIDTH−1, one bit per cycle. At count WIDTH−1 → DONE.
  - DONE: stays while out_ready=0. On out_ready=1 → IDLE, or straight to the next op if in_valid is accepted in the same cycle.
- Operands and opcode are captured on acceptance. Input changes afterwards have no effect.

## Timing
- Acceptance happens on a cycle where in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready.
- Single-cycle ops: out_valid rises the cycle after acceptance. Back-to-back throughput is 1 op/cycle when out_ready is held high.
- MUL/DIV: out_valid rises WIDTH+1 cycles after acceptance. busy is high for exactly WIDTH cycles. in_ready is 0 during iteration.
- result and flags are stable while out_valid=1 && out_ready=0.
- Reset (rst_n=0 at a clock edge), including mid-iteration: state → IDLE, counter cleared, the in-flight op is discarded.
- Reset values of outputs: out_valid=0, result=0, flags=0, busy=0, in_ready=1 from the first cycle after reset.

## Configuration
- ALU_DIV_EN defined: the divider is built and DIV behaves as specified above.
- ALU_DIV_EN undefined: no divider logic is built. DIV is treated as an illegal opcode (single cycle, result 0, illegal=1, div0=0).

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_MOV_I, OP_MOV_R, OP_ADD … OP_LRSH),
  - the FSM state enum (IDLE, EXEC_MUL, EXEC_DIV, DONE),
  - flag bit-index constants.
- Sub-module alu_div_iter is a restoring divider with start/done that is instantiated only under ALU_DIV_EN.
- The MUL iteration lives in alu_core and shares its counter with the divider sequencing.

## Test plan
- ADD 0x7FFF+0x0001, out_ready=1 → next cycle result low 0x8000, ovf=1, carry=0, zero=0. SUB 0x0003−0x0005 → 0xFFFE, carry=0.
- MUL 0xFFFF×0xFFFF → out_valid exactly 17 cycles after acceptance, result 0xFFFE0001, ovf=1, busy high for 16 cycles.
- DIV 100÷7 → quotient 14, remainder 2 after 17 cycles. DIV 5÷0 → next cycle quotient 0xFFFF, remainder 5, div0=1.
- Hold out_ready=0 for 5 cycles after an XOR 0xAAAA^0xFFFF → result stays 0x5555 and in_ready=0. Then out_ready=1 with a new op offered → accepted the same cycle.
- Stream 4 back-to-back LLSH ops (a=0x0001, b=0,4,15,16) with out_ready=1 → one result per cycle: 0x0001, 0x0010, 0x8000, 0x0000 (zero=1).
- Drive rst_n=0 at iteration 8 of a MUL → next cycle out_valid=0, busy=0, in_ready=1. Opcode 0x3F → illegal=1, result 0. With ALU_DIV_EN undefined, DIV → illegal=1.
